// File: rtl/srl_fifo_pkg.sv
// ---------------------------------------------------------------------------
// srl_fifo_pkg
// Shared constants and helpers for the shift-register start-token FIFO.
//   clog2        : constant ceil(log2(value)), used for address sizing checks
//   count_width  : occupancy counter width for a given read-address width
//   DEFAULT_*    : default geometry of srl_start_fifo
// ---------------------------------------------------------------------------
package srl_fifo_pkg;

    // Ceiling log2, usable in parameter expressions at elaboration time.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // The occupancy counter needs one bit more than the read address so it
    // can hold the value DEPTH (and DEPTH+1 with the output stage enabled).
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

    localparam int DEFAULT_DATA_WIDTH  = 1;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_ADDR_WIDTH  = clog2(DEFAULT_DEPTH);
    localparam int DEFAULT_COUNT_WIDTH = count_width(DEFAULT_ADDR_WIDTH);

endpackage

// File: rtl/srl_start_fifo_shiftreg.sv
// ---------------------------------------------------------------------------
// srl_start_fifo_shiftreg
// Pure storage for the SRL FIFO. On a write every entry moves up by one and
// entry 0 takes the new word; the read port is an asynchronous mux indexed by
// addr. There is deliberately no reset so synthesis can map it onto LUT-SRLs.
// Ports:
//   clk   in   rising-edge clock
//   we    in   shift enable (one push)
//   addr  in   ADDR_WIDTH read index (entry 0 = newest)
//   din   in   DATA_WIDTH word shifted into entry 0
//   dout  out  DATA_WIDTH word stored at entry addr
// ---------------------------------------------------------------------------
module srl_start_fifo_shiftreg #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Shift chain: the whole array moves together, which is what lets the
    // tools fold each bit column into a single SRL primitive.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[addr];

endmodule

// File: rtl/srl_start_fifo.sv
// ---------------------------------------------------------------------------
// srl_start_fifo
// Parametrised first-word-fall-through FIFO built on a shift register, used
// between dataflow processes for start tokens or narrow data words.
// Optional build macro: SRL_START_FIFO_OUT_REG_EN adds a registered output
// stage (capacity DEPTH+1, write-to-read latency 2). Without it the head word
// is read combinationally from the SRL (capacity DEPTH, latency 1).
// Ports:
//   clk             in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   if_write        in   producer write request
//   if_din          in   DATA_WIDTH write data
//   if_full_n       out  high while space is available
//   if_almost_full  out  high while occupancy >= AF_THRESH
//   if_read         in   consumer read request
//   if_dout         out  DATA_WIDTH head-of-queue word
//   if_empty_n      out  high while if_dout is valid
//   if_count        out  ADDR_WIDTH+1 occupancy
// ---------------------------------------------------------------------------
module srl_start_fifo
    import srl_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_THRESH  = DEPTH - 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count
);

    localparam int              CW      = count_width(ADDR_WIDTH);
    localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);

    // Reject geometries the counter and address logic cannot represent.
    if (DEPTH < 2) begin : g_bad_depth
        $error("srl_start_fifo: DEPTH must be at least 2");
    end
    if (ADDR_WIDTH != clog2(DEPTH)) begin : g_bad_addr_width
        $error("srl_start_fifo: ADDR_WIDTH must equal clog2(DEPTH)");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af_thresh
        $error("srl_start_fifo: AF_THRESH must lie in 1..DEPTH");
    end

    logic [CW-1:0]         srl_count;
    logic [CW-1:0]         srl_count_nxt;
    logic [CW-1:0]         total_nxt;
    logic                  full_n_q;
    logic                  af_q;
    logic                  push;
    logic                  srl_pop;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_dout;

    // Writes are only honoured while the registered full flag says there is
    // room, so a pop in the same cycle never opens a bypass into a full FIFO.
    assign push = if_write & full_n_q;

    // Oldest word sits at entry count-1; at count 0 the address wraps but the
    // data is not marked valid, so the value is irrelevant.
    assign srl_addr = ADDR_WIDTH'(srl_count - ONE_C);

    srl_start_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_shiftreg (
        .clk  (clk),
        .we   (push),
        .addr (srl_addr),
        .din  (if_din),
        .dout (srl_dout)
    );

    // SRL occupancy: a simultaneous push and pop leaves the count alone
    // because the shift already moves the next-oldest word under the pointer.
    always_comb begin
        srl_count_nxt = srl_count;
        case ({push, srl_pop})
            2'b10:   srl_count_nxt = srl_count + ONE_C;
            2'b01:   srl_count_nxt = srl_count - ONE_C;
            default: srl_count_nxt = srl_count;
        endcase
    end

    // Count and flags are registered together from the next-count values so
    // every status output changes on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            srl_count <= '0;
            full_n_q  <= 1'b1;
            af_q      <= 1'b0;
        end else begin
            srl_count <= srl_count_nxt;
            full_n_q  <= (srl_count_nxt != DEPTH_C);
            af_q      <= (total_nxt >= AF_C);
        end
    end

    assign if_full_n      = full_n_q;
    assign if_almost_full = af_q;

`ifdef SRL_START_FIFO_OUT_REG_EN

    logic                  out_valid;
    logic                  out_valid_nxt;
    logic                  out_load;
    logic [DATA_WIDTH-1:0] out_data;

    // The output register accepts a new word when it is being consumed or is
    // currently empty; it pulls from the SRL only if the SRL holds something.
    assign out_load      = (if_read & out_valid) | ~out_valid;
    assign srl_pop       = out_load & (srl_count != '0);
    assign out_valid_nxt = srl_pop | (out_valid & ~out_load);
    assign total_nxt     = srl_count_nxt + CW'(out_valid_nxt);

    // Output stage: holds the head word; resets to zero so if_dout is clean
    // after reset even though the SRL itself is never cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= out_valid_nxt;
            if (srl_pop) begin
                out_data <= srl_dout;
            end
        end
    end

    assign if_dout    = out_data;
    assign if_empty_n = out_valid;
    assign if_count   = srl_count + CW'(out_valid);

`else

    logic empty_n_q;

    assign srl_pop   = if_read & empty_n_q;
    assign total_nxt = srl_count_nxt;

    // Empty flag tracks the same next-count as the other status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            empty_n_q <= 1'b0;
        end else begin
            empty_n_q <= (srl_count_nxt != '0);
        end
    end

    assign if_dout    = srl_dout;
    assign if_empty_n = empty_n_q;
    assign if_count   = srl_count;

`endif

endmodule

// File: tb/tb_srl_start_fifo.sv
// ---------------------------------------------------------------------------
// tb_srl_start_fifo
// Self-checking bench for srl_start_fifo (DEPTH 8, 8-bit words). Follows the
// SRL_START_FIFO_OUT_REG_EN macro so the same file covers both builds.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_srl_start_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int AF    = 7;
`ifdef SRL_START_FIFO_OUT_REG_EN
    localparam int CAP   = DEPTH + 1;
    localparam int LAT   = 2;
`else
    localparam int CAP   = DEPTH;
    localparam int LAT   = 1;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_almost_full;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   if_count;

    int checks = 0;
    int errors = 0;

    // Reference model: words waiting behind the head, plus (with the output
    // stage) the word currently presented at the output.
    logic [DW-1:0] srl_q [$];
    logic [DW-1:0] out_word;
    bit            out_valid;

    srl_start_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .AF_THRESH  (AF)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_write       (if_write),
        .if_din         (if_din),
        .if_full_n      (if_full_n),
        .if_almost_full (if_almost_full),
        .if_read        (if_read),
        .if_dout        (if_dout),
        .if_empty_n     (if_empty_n),
        .if_count       (if_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_count();
        return srl_q.size() + (out_valid ? 1 : 0);
    endfunction

    function automatic bit exp_empty_n();
`ifdef SRL_START_FIFO_OUT_REG_EN
        return out_valid;
`else
        return srl_q.size() > 0;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_head();
`ifdef SRL_START_FIFO_OUT_REG_EN
        return out_word;
`else
        return (srl_q.size() > 0) ? srl_q[0] : '0;
`endif
    endfunction

    task automatic model_reset();
        srl_q.delete();
        out_word  = '0;
        out_valid = 1'b0;
    endtask

    // One clock of FIFO behaviour, decided from the pre-edge state.
    task automatic model_step(input bit wr, input logic [DW-1:0] d, input bit rd);
        bit do_pop;
        bit do_push;
        do_push = wr && (srl_q.size() < DEPTH);
`ifdef SRL_START_FIFO_OUT_REG_EN
        do_pop = rd && out_valid;
        if (do_pop || !out_valid) begin
            if (srl_q.size() > 0) begin
                out_word  = srl_q.pop_front();
                out_valid = 1'b1;
            end else begin
                out_valid = 1'b0;
            end
        end
`else
        do_pop = rd && (srl_q.size() > 0);
        if (do_pop) begin
            void'(srl_q.pop_front());
        end
`endif
        if (do_push) begin
            srl_q.push_back(d);
        end
    endtask

    // Drive one cycle of requests, advance the model, land 1 ns past the edge.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd);
        if_write = wr;
        if_din   = d;
        if_read  = rd;
        @(posedge clk);
        model_step(wr, d, rd);
        #1;
        if_write = 1'b0;
        if_read  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (if_empty_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_empty_n: got %b expected 0", if_empty_n);
        end
        checks++;
        if (if_full_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_full_n: got %b expected 1", if_full_n);
        end
        checks++;
        if (if_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_count: got %0d expected 0", if_count);
        end
        checks++;
        if (if_almost_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_almost_full: got %b expected 0", if_almost_full);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= CAP; i++) begin
            step(1'b1, 8'(8'h10 + i), 1'b0);
            checks++;
            if (if_count !== (AW+1)'(i)) begin
                errors++;
                $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, if_count, i);
            end
            checks++;
            if (if_almost_full !== (i >= AF)) begin
                errors++;
                $display("[TB] FAIL fill_almost_full[%0d]: got %b expected %b", i, if_almost_full, (i >= AF));
            end
            checks++;
            if (if_full_n !== (i < CAP)) begin
                errors++;
                $display("[TB] FAIL fill_full_n[%0d]: got %b expected %b", i, if_full_n, (i < CAP));
            end
        end
        step(1'b1, 8'h99, 1'b0);
        checks++;
        if (if_count !== (AW+1)'(CAP)) begin
            errors++;
            $display("[TB] FAIL overflow_count: got %0d expected %0d", if_count, CAP);
        end
        for (int k = 0; k < CAP; k++) begin
            checks++;
            if (if_empty_n !== 1'b1 || if_dout !== 8'(8'h11 + k)) begin
                errors++;
                $display("[TB] FAIL drain_dout[%0d]: got %h/%b expected %h/1", k, if_dout, if_empty_n, 8'(8'h11 + k));
            end
            step(1'b0, '0, 1'b1);
        end
        checks++;
        if (if_empty_n !== 1'b0 || if_count !== '0) begin
            errors++;
            $display("[TB] FAIL drain_empty: got %b/%0d expected 0/0", if_empty_n, if_count);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h20 + i), 1'b0);
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (if_empty_n !== 1'b1 || if_dout !== 8'(8'h20 + c)) begin
                errors++;
                $display("[TB] FAIL b2b_dout[%0d]: got %h/%b expected %h/1", c, if_dout, if_empty_n, 8'(8'h20 + c));
            end
            step(1'b1, 8'(8'h24 + c), 1'b1);
            checks++;
            if (if_count !== 4'd4) begin
                errors++;
                $display("[TB] FAIL b2b_count[%0d]: got %0d expected 4", c, if_count);
            end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (if_dout !== 8'(8'h34 + k)) begin
                errors++;
                $display("[TB] FAIL b2b_tail[%0d]: got %h expected %h", k, if_dout, 8'(8'h34 + k));
            end
            step(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < CAP; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
        end
        step(1'b1, 8'hEE, 1'b1);
        checks++;
        if (if_count !== (AW+1)'(CAP - 1)) begin
            errors++;
            $display("[TB] FAIL full_rw_count: got %0d expected %0d", if_count, CAP - 1);
        end
        checks++;
        if (if_full_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_rw_full_n: got %b expected 1", if_full_n);
        end
        for (int k = 0; k < CAP - 1; k++) begin
            checks++;
            if (if_empty_n !== 1'b1 || if_dout !== 8'(8'h41 + k)) begin
                errors++;
                $display("[TB] FAIL full_rw_drain[%0d]: got %h/%b expected %h/1", k, if_dout, if_empty_n, 8'(8'h41 + k));
            end
            step(1'b0, '0, 1'b1);
        end
        checks++;
        if (if_empty_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_rw_dropped: got empty_n %b dout %h expected empty", if_empty_n, if_dout);
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 8'h5A, 1'b1);
        checks++;
        if (if_count !== 4'd1) begin
            errors++;
            $display("[TB] FAIL empty_rw_count: got %0d expected 1", if_count);
        end
`ifdef SRL_START_FIFO_OUT_REG_EN
        checks++;
        if (if_empty_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL empty_rw_latency: got empty_n %b expected 0", if_empty_n);
        end
        step(1'b0, '0, 1'b0);
`endif
        checks++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL empty_rw_dout: got %h/%b expected 5a/1", if_dout, if_empty_n);
        end
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0);
        end
        checks++;
        if (if_count !== 4'd5) begin
            errors++;
            $display("[TB] FAIL mid_pre_count: got %0d expected 5", if_count);
        end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (if_count !== '0 || if_empty_n !== 1'b0 || if_full_n !== 1'b1 || if_almost_full !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_async_reset: got count %0d empty_n %b full_n %b af %b expected 0 0 1 0",
                     if_count, if_empty_n, if_full_n, if_almost_full);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 8'hC3, 1'b0);
        for (int i = 1; i < LAT; i++) begin
            step(1'b0, '0, 1'b0);
        end
        checks++;
        if (if_empty_n !== 1'b1 || if_dout !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL mid_post_dout: got %h/%b expected c3/1", if_dout, if_empty_n);
        end
        step(1'b0, '0, 1'b1);
        checks++;
        if (if_empty_n !== 1'b0 || if_count !== '0) begin
            errors++;
            $display("[TB] FAIL mid_post_empty: got %b/%0d expected 0/0", if_empty_n, if_count);
        end
    endtask

    task automatic test_random();
        int wr_pct;
        for (int c = 0; c < 400; c++) begin
            wr_pct = (c < 200) ? 70 : 30;
            step(($urandom_range(0, 99) < wr_pct), 8'($urandom), ($urandom_range(0, 99) < 50));
            checks++;
            if (if_count !== (AW+1)'(exp_count())) begin
                errors++;
                $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", c, if_count, exp_count());
            end
            checks++;
            if (if_empty_n !== exp_empty_n()) begin
                errors++;
                $display("[TB] FAIL rand_empty_n[%0d]: got %b expected %b", c, if_empty_n, exp_empty_n());
            end
            checks++;
            if (if_full_n !== (srl_q.size() < DEPTH)) begin
                errors++;
                $display("[TB] FAIL rand_full_n[%0d]: got %b expected %b", c, if_full_n, (srl_q.size() < DEPTH));
            end
            checks++;
            if (if_almost_full !== (exp_count() >= AF)) begin
                errors++;
                $display("[TB] FAIL rand_almost_full[%0d]: got %b expected %b", c, if_almost_full, (exp_count() >= AF));
            end
            if (exp_empty_n()) begin
                checks++;
                if (if_dout !== exp_head()) begin
                    errors++;
                    $display("[TB] FAIL rand_dout[%0d]: got %h expected %h", c, if_dout, exp_head());
                end
            end
        end
    endtask

    initial begin
        $display("[TB] srl_start_fifo bench, capacity %0d, latency %0d", CAP, LAT);
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_rw();
        test_empty_rw();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/srl_start_fifo.md
Name: srl_start_fifo

Overview:
- Parametrised shift-register (SRL) FIFO.
- Successor of the fixed-depth start-token shift register used between HLS dataflow processes.
- Adds full/empty handshake, occupancy count and programmable almost-full, with generic width and depth.
- Sits between producer and consumer PEs in the Linear_Layer dataflow, carrying start tokens or narrow data words. Maps to LUT-SRL, not BRAM.

Parameters:
- DATA_WIDTH, 1, width of each stored word.
- DEPTH, 8, number of storage entries; must be ≥2; elaboration error otherwise.
- ADDR_WIDTH, 3, read-address width; must equal clog2(DEPTH); elaboration error otherwise.
- AF_THRESH, DEPTH-1, occupancy at or above which if_almost_full is asserted; 1..DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- if_write  in  1  producer write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  high = space available.
- if_almost_full  out  1  registered count ≥ AF_THRESH.
- if_read  in  1  consumer read request.
- if_dout  out  DATA_WIDTH  head-of-queue word (first-word-fall-through).
- if_empty_n  out  1  high = if_dout valid.
- if_count  out  ADDR_WIDTH+1  current occupancy 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): count=0, if_empty_n=0, if_full_n=1, if_almost_full=0.
- Storage array is not reset, so that it infers SRL; if_dout is don't-care while if_empty_n=0.
- push = if_write & if_full_n; pop = if_read & if_empty_n. Requests without the matching flag are ignored: no state change, no error.
- On push: all entries shift up by one, entry 0 takes if_din.
- if_dout = entry[count-1] (oldest word), combinational from the registered count.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; shift occurs, so the read pointer still addresses the next-oldest word.
- if_full_n, if_empty_n and if_almost_full are registered, computed from next-count. All update in the same cycle as count.
- Latency: a word written at edge N is visible on if_dout with if_empty_n=1 after edge N. Write-to-read latency is 1 cycle.
- Full (count=DEPTH): if_full_n=0, so push is blocked even if a pop happens in the same cycle (no full-bypass). if_full_n returns to 1 the cycle after a pop.
- Empty (count=0): if_empty_n=0, so a simultaneous read is ignored and the push proceeds. No empty-bypass.
- Reset asserted mid-operation: all contents are logically discarded immediately; flags take reset values asynchronously.
- The count never wraps. Saturation at 0 and DEPTH is guaranteed by the flag gating.

Optional Feature:
- Macro: SRL_START_FIFO_OUT_REG_EN.
- Defined:
  - if_dout is driven from a registered output stage fed by the SRL. Output stage reset-valued to 0.
  - if_empty_n reflects output-register validity.
  - The register refills from the SRL on pop or when invalid.
  - Total capacity becomes DEPTH+1; if_count includes the output stage.
  - Write-to-read latency becomes 2 cycles.
  - AF_THRESH is compared against the total count.
- Undefined: behaviour exactly as above (combinational head read, latency 1).

Decomposition:
- Package srl_fifo_pkg:
  - clog2 constant function.
  - Default DATA_WIDTH/DEPTH constants.
  - Localparam for count width (ADDR_WIDTH+1).
- Sub-module srl_start_fifo_shiftreg: pure storage, ports clk, we, addr, din, dout; no reset.
- Top module: count, flags, handshake gating and the optional output stage.

Test Plan:
- Reset, DEPTH=8, DATA_WIDTH=8: after release → if_empty_n=0, if_full_n=1, if_count=0, if_almost_full=0.
- Write 0x11..0x18 on consecutive cycles, no reads:
  - if_count reaches 8, if_full_n=0 after the 8th edge.
  - if_almost_full=1 after the 7th edge.
  - 9th write 0x99 ignored.
  - Then read 8 → dout 0x11..0x18 in order, if_empty_n=0 after the last read.
- Fill to 4, then simultaneous read+write for 20 cycles with an incrementing pattern → if_count stays 4, output order strictly FIFO, no loss.
- Full plus simultaneous read/write: exactly one word leaves, the written word is dropped, if_count=7 next cycle.
- Empty plus simultaneous read/write of 0x5A: read ignored, if_count=1, if_dout=0x5A next cycle.
- Assert reset_n=0 mid-stream at count=5 → flags and count reset asynchronously within the same cycle; post-reset write/read of 0xC3 returns 0xC3. Repeat all with SRL_START_FIFO_OUT_REG_EN, checking 2-cycle latency and capacity 9.
